// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int unsigned IF_PKT_W         = 64;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM address/data, redirect request and decode valid/ready bundle of the fetch stage.
interface inst_fetch_if;
  logic [31:0] inst_addr;
  logic [31:0] inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;

  modport master (
    output inst_addr, if_valid_o, if_inst_o, if_pc_o,
    input  inst_i, redirect_i, redirect_pc_i, if_ready_i
  );

  modport slave (
    input  inst_addr, if_valid_o, if_inst_o, if_pc_o,
    output inst_i, redirect_i, redirect_pc_i, if_ready_i
  );
endinterface

// File: rtl/inst_fetch_skid_fifo.sv
// 2-entry skid FIFO holding {pc,inst} responses that decode could not take yet.
module if_skid_fifo
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       enq,
  input  if_pkt_t    enq_data,
  input  logic       deq,
  output if_pkt_t    head,
  output logic [1:0] cnt
);

  if_pkt_t    mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (enq) wr_q <= ~wr_q;
      if (deq) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(enq) - 2'(deq);
    end
  end

  // Storage carries no reset; only the pointers/count define what is live.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_q] <= enq_data;
  end

  assign head = mem_q[rd_q];
  assign cnt  = cnt_q;

  no_overflow:  assert property (@(posedge clk) disable iff (rst)
                  !(enq && !deq && !flush && cnt_q == 2'd2));
  no_underflow: assert property (@(posedge clk) disable iff (rst)
                  !(deq && cnt_q == 2'd0));

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues ROM reads under a 2-credit rule and hands
// {pc,inst} to decode, either straight from the ROM or from the skid FIFO.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IROM_SPACE = 4096
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(IROM_SPACE);

  logic [31:0] pc_q;
  logic [31:0] resp_pc_q;
  logic        inflight_q;
  logic [1:0]  fifo_cnt;
  logic [2:0]  pending;
  logic        deq;
  logic        issue;
  logic        enq;
  logic        fifo_deq;
  if_pkt_t     head;
  if_pkt_t     out_pkt;

  assign deq = bus.if_valid_o & bus.if_ready_i;

  // Outstanding responses after this edge must fit the 2-entry FIFO.
  assign pending = 3'(fifo_cnt) + 3'(inflight_q) - 3'(deq);
  assign issue   = ~bus.redirect_i & (pending <= 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= word_align(RESET_PC);
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else if (bus.redirect_i) begin
      pc_q       <= word_align(bus.redirect_pc_i);
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q       <= pc_q + 32'd4;
      resp_pc_q  <= pc_q;
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  // A returning response bypasses the FIFO only when it is empty and decode takes it.
  assign enq      = inflight_q & ~bus.redirect_i & ~(deq & (fifo_cnt == 2'd0));
  assign fifo_deq = deq & (fifo_cnt != 2'd0);

  if_skid_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_i),
    .enq      (enq),
    .enq_data ('{pc: resp_pc_q, inst: bus.inst_i}),
    .deq      (fifo_deq),
    .head     (head),
    .cnt      (fifo_cnt)
  );

  always_comb begin
    out_pkt = '{pc: '0, inst: NOP_INST};
    if (fifo_cnt != 2'd0)
      out_pkt = head;
    else if (inflight_q)
      out_pkt = '{pc: resp_pc_q, inst: bus.inst_i};
  end

  assign bus.inst_addr  = 32'(pc_q[ADDR_WIDTH+1:2]);
  assign bus.if_valid_o = ~bus.redirect_i & ((fifo_cnt != 2'd0) | inflight_q);
  assign bus.if_pc_o    = out_pkt.pc;
  assign bus.if_inst_o  = out_pkt.inst;

endmodule
